// File: rtl/fifo_ctl.sv
// fifo_ctl -- synchronous FIFO controller in front of a dual-port RAM (dpram).
// The FIFO holds 2^AW words of DW bits. Pushes write through RAM port A and
// pops read through RAM port X. Popped data arrives one enabled cycle after
// the pop, because the RAM registers the read address.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   ena_i                   global clock enable (shared with the RAM)
//   wstb_i, wdat_i, wful_o  push request, push data, full flag
//   rstb_i, rdat_o, rvld_o  pop request, popped data, popped data valid
//   remp_o, cnt_o           empty flag, occupancy 0..2^AW
//   ovf_o, udf_o            sticky push-while-full / pop-while-empty
//   ram_*                   connections to the RAM (A = write, X = read)
module fifo_ctl #(
    parameter int AW = 5,
    parameter int DW = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ena_i,
    input  logic          wstb_i,
    input  logic [DW-1:0] wdat_i,
    output logic          wful_o,
    input  logic          rstb_i,
    output logic [DW-1:0] rdat_o,
    output logic          rvld_o,
    output logic          remp_o,
    output logic [AW:0]   cnt_o,
    output logic          ovf_o,
    output logic          udf_o,
    output logic [AW-1:0] ram_adr_o,
    output logic [DW-1:0] ram_dat_o,
    output logic          ram_wre_o,
    output logic [AW-1:0] ram_xadr_o,
    output logic [DW-1:0] ram_xdat_o,
    output logic          ram_xwre_o,
    input  logic [DW-1:0] ram_xdat_i
);

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [AW:0] wptr, rptr, cnt;
    logic        ovf, udf, rvld;
    logic        push, pop;
    logic        full, empty;

    // Flags come only from registered pointers, never from the request strobes.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    // Gating pop by !empty rejects the pop half of a push+pop on an empty
    // FIFO. Gating push by !full rejects the push half on a full FIFO.
    assign push = ena_i && wstb_i && !full  && !rst_i;
    assign pop  = ena_i && rstb_i && !empty && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
            udf  <= 1'b0;
            rvld <= 1'b0;
        end else if (ena_i) begin
            if (push) wptr <= wptr + (AW+1)'(1);
            if (pop)  rptr <= rptr + (AW+1)'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
            if (wstb_i && full)  ovf <= 1'b1;
            if (rstb_i && empty) udf <= 1'b1;
            // Data valid follows the pop by one enabled cycle, matching the
            // RAM's registered read address.
            rvld <= pop;
        end
    end

    assign wful_o     = full;
    assign remp_o     = empty;
    assign cnt_o      = cnt;
    assign ovf_o      = ovf;
    assign udf_o      = udf;
    assign rvld_o     = rvld;
    assign rdat_o     = ram_xdat_i;

    assign ram_adr_o  = wptr[AW-1:0];
    assign ram_dat_o  = wdat_i;
    assign ram_wre_o  = push;
    assign ram_xadr_o = rptr[AW-1:0];
    assign ram_xdat_o = '0;
    assign ram_xwre_o = 1'b0;

endmodule
